// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types for the UTM transmit and receive paths.
package usb_utmi_pkg;

  typedef logic [7:0] bus8_t;

  typedef enum logic [1:0] {
    OP_NORMAL      = 2'b00,
    OP_NON_DRIVING = 2'b01,
    OP_DIS_BS_NRZI = 2'b10,
    OP_RSVD        = 2'b11
  } utmi_op_mode_t;

endpackage

// File: rtl/usb_utm_tx.sv
// UTM transmit path: serialises SIE bytes into SYNC, bit-stuffed
// NRZI data and EOP on the full-speed single-ended line pair.
module usb_utm_tx
  import usb_utmi_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op_mode,
  input  logic [7:0] data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       dp_tx,
  output logic       dn_tx,
  output logic       tx_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  localparam int TW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0] T_START = TW'(CLK_PER_BIT - 2);

  state_t      state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic        bypass, bypass_d;
  bus8_t       shift, shift_d;
  logic [3:0]  bits_left, bits_d;
  logic [2:0]  ones, ones_d;
  bus8_t       hold, hold_d;
  logic        hold_full, hold_full_d;
  logic        eop_second, eop_d;
  logic        dp_d, dn_d, oe_d;

  logic strobe;
  logic stuff_due;
  logic boundary;
  logic xfer;
  logic bit_en;
  logic bit_val;
  logic line_nxt;

  assign strobe    = (timer == T_LAST);
  assign stuff_due = (ones == 3'd6);
  assign boundary  = strobe && !stuff_due && (bits_left == 4'd0);

  // Ready drops on the boundary clk so a byte arriving then opens
  // the next packet instead of being swallowed by this one's EOP.
  assign tx_ready = !hold_full && !boundary &&
                    (state == S_SYNC || state == S_DATA);
  assign xfer     = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      bypass     <= 1'b0;
      shift      <= '0;
      bits_left  <= '0;
      ones       <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      eop_second <= 1'b0;
      dp_tx      <= 1'b1;
      dn_tx      <= 1'b0;
      tx_oe      <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      bypass     <= bypass_d;
      shift      <= shift_d;
      bits_left  <= bits_d;
      ones       <= ones_d;
      hold       <= hold_d;
      hold_full  <= hold_full_d;
      eop_second <= eop_d;
      dp_tx      <= dp_d;
      dn_tx      <= dn_d;
      tx_oe      <= oe_d;
    end
  end

  always_comb begin
    state_d     = state;
    timer_d     = timer;
    bypass_d    = bypass;
    shift_d     = shift;
    bits_d      = bits_left;
    ones_d      = ones;
    hold_d      = hold;
    hold_full_d = hold_full;
    eop_d       = eop_second;
    dp_d        = dp_tx;
    dn_d        = dn_tx;
    oe_d        = tx_oe;
    bit_en      = 1'b0;
    bit_val     = 1'b0;
    line_nxt    = dp_tx;

    if (state != S_IDLE) begin
      timer_d = strobe ? '0 : timer + 1'b1;
    end

    if (xfer) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        timer_d = '0;
        if (tx_valid && op_mode != OP_NON_DRIVING) begin
          state_d  = S_SYNC;
          timer_d  = T_START;
          bypass_d = (op_mode == OP_DIS_BS_NRZI);
          shift_d  = 8'h80;
          bits_d   = 4'd8;
          ones_d   = '0;
          eop_d    = 1'b0;
        end
      end
      S_SYNC, S_DATA: begin
        if (strobe) begin
          oe_d = 1'b1;
          if (stuff_due) begin
            bit_en  = 1'b1;
            bit_val = 1'b0;
          end else if (bits_left != 4'd0) begin
            bit_en  = 1'b1;
            bit_val = shift[0];
            shift_d = {1'b0, shift[7:1]};
            bits_d  = bits_left - 1'b1;
          end else if (hold_full) begin
            bit_en      = 1'b1;
            bit_val     = hold[0];
            shift_d     = {1'b0, hold[7:1]};
            bits_d      = 4'd7;
            hold_full_d = 1'b0;
            state_d     = S_DATA;
          end else begin
            dp_d    = 1'b0;
            dn_d    = 1'b0;
            eop_d   = 1'b0;
            state_d = S_EOP_SE0;
          end
        end
      end
      S_EOP_SE0: begin
        if (strobe) begin
          if (!eop_second) begin
            eop_d = 1'b1;
          end else begin
            dp_d    = 1'b1;
            dn_d    = 1'b0;
            state_d = S_EOP_J;
          end
        end
      end
      S_EOP_J: begin
        if (strobe) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // dp_tx doubles as the NRZI line state (1 = J)
    if (bit_en) begin
      if (bypass) begin
        line_nxt = bit_val;
      end else begin
        line_nxt = bit_val ? dp_tx : !dp_tx;
        ones_d   = !bit_val ? 3'd0 :
                   (ones == 3'd7) ? 3'd7 : ones + 3'd1;
      end
      dp_d = line_nxt;
      dn_d = !line_nxt;
    end
  end

endmodule

// File: tb/tb_usb_utm_tx.sv
// Directed bench for usb_utm_tx: line symbols per clk, handshakes,
// stuffing, bypass mode, non-driving mode and mid-packet reset.
module tb_usb_utm_tx;
  import usb_utmi_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] op_mode = OP_NORMAL;
  logic [7:0] data_in = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, dp_tx, dn_tx, tx_oe;

  int n_chk = 0;
  int n_fail = 0;
  int hs_cnt = 0;

  string raw_a, raw_b;
  int    lat_a, lat_b, r_a, r_b, hs0, cnt;

  always #5 clk = ~clk;

  usb_utm_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .op_mode(op_mode),
    .data_in(data_in),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .dp_tx(dp_tx),
    .dn_tx(dn_tx),
    .tx_oe(tx_oe)
  );

  always @(posedge clk)
    if (!rst && tx_valid && tx_ready) hs_cnt <= hs_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic byte sym();
    if (dp_tx && !dn_tx) return "J";
    if (!dp_tx && dn_tx) return "K";
    if (!dp_tx && !dn_tx) return "0";
    return "1";
  endfunction

  // lat = negedges with tx_oe low before the packet; raw = one char per clk
  task automatic capture(output string raw, output int lat);
    int n;
    raw = "";
    lat = 0;
    @(negedge clk);
    while (!tx_oe && lat < 400) begin
      lat++;
      @(negedge clk);
    end
    if (!tx_oe) check("oe_rise_timeout", 0, 1);
    n = 0;
    while (tx_oe && n < 2000) begin
      raw = $sformatf("%s%c", raw, sym());
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_line(input string tag, input string raw,
                            input string exp);
    int idx;
    int got;
    check({tag, " clks"}, raw.len(), exp.len() * CPB);
    for (int i = 0; i < exp.len(); i++) begin
      for (int k = 0; k < CPB; k++) begin
        idx = i * CPB + k;
        got = (idx < raw.len()) ? int'(raw[idx]) : 0;
        check($sformatf("%s sym%0d", tag, i), got, int'(exp[i]));
      end
    end
  endtask

  task automatic sie_send(input logic [7:0] b, input int delay,
                          input bit wait_rdy, output int rdy_seen);
    int n;
    rdy_seen = 0;
    if (wait_rdy) begin
      n = 0;
      @(negedge clk);
      while (!tx_ready && n < 500) begin
        n++;
        @(negedge clk);
      end
      if (!tx_ready) check("rdy_timeout", 0, 1);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (tx_ready) rdy_seen++;
    end
    data_in  = b;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("hs_timeout", 0, 1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_se0();
    int n;
    n = 0;
    @(negedge clk);
    while (!(tx_oe && !dp_tx && !dn_tx) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) check("se0_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst oe", tx_oe, 0);
    check("rst dp", dp_tx, 1);
    check("rst dn", dn_tx, 0);
    check("rst ready", tx_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    hs0 = hs_cnt;
    fork
      sie_send(8'hC3, 0, 1'b0, r_a);
      capture(raw_a, lat_a);
    join
    check("c3 lat", lat_a, 3);
    check_line("c3", raw_a, "KJKJKJKKKKJKJKKK00J");
    check("c3 hs", hs_cnt - hs0, 1);

    repeat (3) @(posedge clk);
    #1;
    hs0 = hs_cnt;
    fork
      begin
        sie_send(8'hFF, 0, 1'b0, r_a);
        sie_send(8'hFF, 0, 1'b1, r_b);
      end
      capture(raw_a, lat_a);
    join
    check_line("ff", raw_a, "KJKJKJKKKKKKKJJJJJJJKKKKKK00J");
    check("ff hs", hs_cnt - hs0, 2);

    repeat (3) @(posedge clk);
    #1;
    hs0 = hs_cnt;
    fork
      begin
        sie_send(8'h00, 0, 1'b0, r_a);
        sie_send(8'h01, 10, 1'b1, r_b);
        check("late rdy_held", r_b, 10);
        wait_se0();
        sie_send(8'h02, 0, 1'b0, r_a);
      end
      begin
        capture(raw_a, lat_a);
        capture(raw_b, lat_b);
      end
    join
    check_line("late a", raw_a, "KJKJKJKKJKJKJKJKKJKJKJKJ00J");
    check("late gap", lat_b, 2);
    check_line("late b", raw_b, "KJKJKJKKJJKJKJKJ00J");
    check("late hs", hs_cnt - hs0, 3);

    repeat (3) @(posedge clk);
    #1;
    hs0 = hs_cnt;
    op_mode = OP_DIS_BS_NRZI;
    fork
      begin
        sie_send(8'hFF, 0, 1'b0, r_a);
        op_mode = OP_NORMAL;
      end
      capture(raw_a, lat_a);
    join
    check_line("bypass", raw_a, "KKKKKKKJJJJJJJJJ00J");
    check("bypass hs", hs_cnt - hs0, 1);

    repeat (3) @(posedge clk);
    #1;
    hs0 = hs_cnt;
    op_mode  = OP_NON_DRIVING;
    data_in  = 8'h55;
    tx_valid = 1'b1;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_oe || tx_ready) cnt++;
    end
    check("nondrv active", cnt, 0);
    check("nondrv hs", hs_cnt - hs0, 0);
    tx_valid = 1'b0;
    op_mode  = OP_NORMAL;

    repeat (3) @(posedge clk);
    #1;
    sie_send(8'h11, 0, 1'b0, r_a);
    sie_send(8'h22, 0, 1'b1, r_b);
    repeat (8) @(negedge clk);
    check("pre-rst oe", tx_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid-rst oe", tx_oe, 0);
    check("mid-rst dp", dp_tx, 1);
    check("mid-rst dn", dn_tx, 0);
    check("mid-rst ready", tx_ready, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    hs0 = hs_cnt;
    fork
      sie_send(8'hC3, 0, 1'b0, r_a);
      capture(raw_a, lat_a);
    join
    check("post-rst lat", lat_a, 3);
    check_line("post-rst", raw_a, "KJKJKJKKKKJKJKKK00J");
    check("post-rst hs", hs_cnt - hs0, 1);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
